// File: rtl/ring_arb_pkg.sv
// ----------------------------------------------------------------------------
// ring_arb_pkg
// Shared types and helpers for the ring token arbiter.
//   arb_state_t   : arbiter FSM states (IDLE, GRANT, GAP)
//   onehot_to_idx : binary index of the set bit of a one-hot vector
//   rotl1         : rotate a one-hot vector left by one inside 'width' bits
// Helpers work on a fixed MAX_N-bit container so that any N_REQ up to MAX_N
// can use them; callers zero-extend on the way in and truncate on the way out.
// ----------------------------------------------------------------------------
package ring_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } arb_state_t;

    localparam int MAX_N     = 32;
    localparam int MAX_IDX_W = 5;

    // OR together the indices of all set bits; for a one-hot input this is
    // exactly the index of the single set bit, and zero for an all-zero input.
    function automatic logic [MAX_IDX_W-1:0] onehot_to_idx(input logic [MAX_N-1:0] vec);
        logic [MAX_IDX_W-1:0] idx;
        idx = {MAX_IDX_W{1'b0}};
        for (int i = 0; i < MAX_N; i++) begin
            if (vec[i]) begin
                idx = idx | MAX_IDX_W'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    // Rotate left by one within the low 'width' bits: bit width-1 wraps to bit 0.
    // Bits at or above 'width' are always returned as zero.
    function automatic logic [MAX_N-1:0] rotl1(input logic [MAX_N-1:0] vec, input int width);
        logic [MAX_N-1:0] res;
        res = {MAX_N{1'b0}};
        for (int i = 1; i < MAX_N; i++) begin
            if (i < width) begin
                res[i] = vec[i-1];
            end else begin
                res[i] = 1'b0;
            end
        end
        res[0] = vec[width-1];
        return res;
    endfunction

endpackage

// File: rtl/ring_rr_pick.sv
// ----------------------------------------------------------------------------
// ring_rr_pick
// Combinational circular priority picker. Starting at the position marked by
// the one-hot token and scanning upward with wrap, the first set request wins.
// Ports:
//   token  [N_REQ-1:0] in  : one-hot start position (highest priority)
//   req    [N_REQ-1:0] in  : request vector
//   winner [N_REQ-1:0] out : one-hot winner, zero when no request
//   found             out : at least one request present
// The request vector is doubled so a plain lowest-bit-first encoder over the
// doubled word performs the wrap-around scan: the lower copy is masked by the
// thermometer of the token (positions at or above the token), the upper copy
// is left open and supplies the wrapped positions below the token.
// ----------------------------------------------------------------------------
module ring_rr_pick
    import ring_arb_pkg::*;
#(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0] token,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] winner,
    output logic             found
);

    logic [N_REQ-1:0]   therm_s;
    logic [2*N_REQ-1:0] dbl_s;
    logic [2*N_REQ-1:0] masked_s;
    logic [2*N_REQ-1:0] first_s;

    // Thermometer mask, doubled-vector scan and lowest-set-bit isolation.
    always_comb begin
        // token - 1 sets every bit below the token; inverting keeps token and above.
        therm_s  = ~(token - {{(N_REQ-1){1'b0}}, 1'b1});
        dbl_s    = {req, req};
        masked_s = dbl_s & {{N_REQ{1'b1}}, therm_s};
        // x & -x isolates the lowest set bit, i.e. the first hit of the scan.
        first_s  = masked_s & (~masked_s + {{(2*N_REQ-1){1'b0}}, 1'b1});
        // Fold both halves back; at most one of them carries the single hit.
        winner   = first_s[N_REQ-1:0] | first_s[2*N_REQ-1:N_REQ];
        found    = |req;
    end

endmodule

// File: rtl/ring_token_arbiter.sv
// ----------------------------------------------------------------------------
// ring_token_arbiter
// Round-robin arbiter sharing one resource among N_REQ requesters. A one-hot
// token rotates like a ring counter and marks the highest-priority requester.
// Each grant is registered, one-hot, and limited to MAX_HOLD cycles; every
// release is followed by one dead GAP cycle during which the token advances
// past the previous owner.
// Ports:
//   CK      in  1            : clock, rising edge
//   RST     in  1            : synchronous active-high reset
//   REQ     in  N_REQ        : level requests, held until done
//   GNT     out N_REQ        : registered one-hot grant or zero
//   GNT_IDX out clog2(N_REQ) : binary index of the owner, 0 with no grant
//   BUSY    out 1            : GNT is non-zero
//   PREEMPT out 1            : high in the GAP cycle after a hold-limit release
//   TOKEN   out N_REQ        : one-hot priority pointer
// ----------------------------------------------------------------------------
module ring_token_arbiter
    import ring_arb_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int MAX_HOLD = 8
) (
    input  logic                     CK,
    input  logic                     RST,
    input  logic [N_REQ-1:0]         REQ,
    output logic [N_REQ-1:0]         GNT,
    output logic [$clog2(N_REQ)-1:0] GNT_IDX,
    output logic                     BUSY,
    output logic                     PREEMPT,
    output logic [N_REQ-1:0]         TOKEN
);

    localparam int IDX_W  = $clog2(N_REQ);
    localparam int HOLD_W = $clog2(MAX_HOLD + 1);

    arb_state_t         state_r;
    arb_state_t         state_n_s;
    logic [N_REQ-1:0]   gnt_r;
    logic [N_REQ-1:0]   gnt_n_s;
    logic [IDX_W-1:0]   gnt_idx_r;
    logic [IDX_W-1:0]   gnt_idx_n_s;
    logic               busy_r;
    logic               preempt_r;
    logic               preempt_n_s;
    logic [N_REQ-1:0]   token_r;
    logic [N_REQ-1:0]   token_n_s;
    logic [HOLD_W-1:0]  hold_r;
    logic [HOLD_W-1:0]  hold_n_s;

    logic [N_REQ-1:0]   winner_s;
    logic               found_s;
    logic               owner_req_s;
    logic               at_limit_s;

    ring_rr_pick #(
        .N_REQ (N_REQ)
    ) u_pick (
        .token  (token_r),
        .req    (REQ),
        .winner (winner_s),
        .found  (found_s)
    );

    // Owner status: is the current owner still requesting, and is its tenure used up.
    always_comb begin
        owner_req_s = |(gnt_r & REQ);
        at_limit_s  = (hold_r == HOLD_W'(MAX_HOLD));
    end

    // Next-state and next-output logic of the arbiter FSM.
    always_comb begin
        state_n_s   = state_r;
        gnt_n_s     = gnt_r;
        gnt_idx_n_s = gnt_idx_r;
        preempt_n_s = 1'b0;
        token_n_s   = token_r;
        hold_n_s    = hold_r;

        case (state_r)
            IDLE, GAP: begin
                if (found_s) begin
                    state_n_s   = GRANT;
                    gnt_n_s     = winner_s;
                    gnt_idx_n_s = IDX_W'(onehot_to_idx(MAX_N'(winner_s)));
                    hold_n_s    = HOLD_W'(1);
                end else begin
                    // Token stays put while nobody asks.
                    state_n_s   = IDLE;
                    gnt_n_s     = {N_REQ{1'b0}};
                    gnt_idx_n_s = {IDX_W{1'b0}};
                    hold_n_s    = {HOLD_W{1'b0}};
                end
            end

            GRANT: begin
                if (!owner_req_s || at_limit_s) begin
                    // A simultaneous drop and limit is a normal release, so
                    // PREEMPT only fires when the owner still wants the slot.
                    state_n_s   = GAP;
                    gnt_n_s     = {N_REQ{1'b0}};
                    gnt_idx_n_s = {IDX_W{1'b0}};
                    preempt_n_s = owner_req_s;
                    token_n_s   = N_REQ'(rotl1(MAX_N'(gnt_r), N_REQ));
                    hold_n_s    = {HOLD_W{1'b0}};
                end else begin
                    hold_n_s    = hold_r + HOLD_W'(1);
                end
            end

            default: begin
                state_n_s   = IDLE;
                gnt_n_s     = {N_REQ{1'b0}};
                gnt_idx_n_s = {IDX_W{1'b0}};
                token_n_s   = {{(N_REQ-1){1'b0}}, 1'b1};
                hold_n_s    = {HOLD_W{1'b0}};
            end
        endcase
    end

    // State, counter, token and output registers with synchronous reset.
    always_ff @(posedge CK) begin
        if (RST) begin
            state_r   <= IDLE;
            gnt_r     <= {N_REQ{1'b0}};
            gnt_idx_r <= {IDX_W{1'b0}};
            busy_r    <= 1'b0;
            preempt_r <= 1'b0;
            token_r   <= {{(N_REQ-1){1'b0}}, 1'b1};
            hold_r    <= {HOLD_W{1'b0}};
        end else begin
            state_r   <= state_n_s;
            gnt_r     <= gnt_n_s;
            gnt_idx_r <= gnt_idx_n_s;
            busy_r    <= |gnt_n_s;
            preempt_r <= preempt_n_s;
            token_r   <= token_n_s;
            hold_r    <= hold_n_s;
        end
    end

    assign GNT     = gnt_r;
    assign GNT_IDX = gnt_idx_r;
    assign BUSY    = busy_r;
    assign PREEMPT = preempt_r;
    assign TOKEN   = token_r;

endmodule

// File: tb/tb_ring_token_arbiter.sv
// ----------------------------------------------------------------------------
// tb_ring_token_arbiter
// Self-checking bench for ring_token_arbiter (N_REQ=4, MAX_HOLD=8).
// A behavioural model tracks the owner number, its tenure length and the
// priority position as plain integers; after every clock edge all DUT outputs
// are compared against it. Directed scenarios add literal expectations, then a
// randomized phase drives flickering requests with occasional resets.
// ----------------------------------------------------------------------------
module tb_ring_token_arbiter;

    localparam int N  = 4;
    localparam int MH = 8;

    logic         CK;
    logic         RST;
    logic [N-1:0] REQ;
    logic [N-1:0] GNT;
    logic [1:0]   GNT_IDX;
    logic         BUSY;
    logic         PREEMPT;
    logic [N-1:0] TOKEN;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model state.
    int m_owner = -1;   // -1: nobody holds the grant
    int m_hold  = 0;    // cycles the current owner has held the grant
    int m_ptr   = 0;    // index of the highest-priority requester
    bit m_pre   = 1'b0;

    ring_token_arbiter #(
        .N_REQ    (N),
        .MAX_HOLD (MH)
    ) dut (
        .CK      (CK),
        .RST     (RST),
        .REQ     (REQ),
        .GNT     (GNT),
        .GNT_IDX (GNT_IDX),
        .BUSY    (BUSY),
        .PREEMPT (PREEMPT),
        .TOKEN   (TOKEN)
    );

    initial CK = 1'b0;
    always #5 CK = ~CK;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // Circular scan from 'ptr' upward; returns -1 when nobody requests.
    function automatic int pick(input logic [N-1:0] r, input int ptr);
        for (int off = 0; off < N; off++) begin
            if (r[(ptr + off) % N]) return (ptr + off) % N;
        end
        return -1;
    endfunction

    task automatic model_update(input logic [N-1:0] r, input logic rs);
        int w;
        if (rs) begin
            m_owner = -1; m_hold = 0; m_ptr = 0; m_pre = 1'b0;
        end else if (m_owner >= 0) begin
            if (!r[m_owner] || m_hold == MH) begin
                m_pre   = r[m_owner];
                m_ptr   = (m_owner + 1) % N;
                m_owner = -1;
                m_hold  = 0;
            end else begin
                m_hold++;
                m_pre = 1'b0;
            end
        end else begin
            m_pre = 1'b0;
            w = pick(r, m_ptr);
            if (w >= 0) begin
                m_owner = w;
                m_hold  = 1;
            end
        end
    endtask

    task automatic compare_model();
        logic [N-1:0] e_gnt;
        logic [1:0]   e_idx;
        logic [N-1:0] e_tok;
        e_gnt = (m_owner >= 0) ? N'(1 << m_owner) : {N{1'b0}};
        e_idx = (m_owner >= 0) ? 2'(m_owner) : 2'd0;
        e_tok = N'(1 << m_ptr);
        chk("gnt",     32'(GNT),     32'(e_gnt));
        chk("gnt_idx", 32'(GNT_IDX), 32'(e_idx));
        chk("busy",    32'(BUSY),    32'(m_owner >= 0));
        chk("preempt", 32'(PREEMPT), 32'(m_pre));
        chk("token",   32'(TOKEN),   32'(e_tok));
    endtask

    // One clock: drive inputs, let the edge happen, advance the model, compare.
    task automatic step(input logic [N-1:0] r, input logic rs);
        REQ = r;
        RST = rs;
        @(posedge CK);
        model_update(r, rs);
        #1;
        compare_model();
    endtask

    initial begin
        logic [N-1:0] rr;
        logic [N-1:0] flip;
        int k;

        REQ = 4'b0000;
        RST = 1'b1;
        #1;

        // Reset then idle.
        step(4'b0000, 1'b1);
        step(4'b0000, 1'b1);
        chk("rst_gnt",     32'(GNT),     32'h0);
        chk("rst_gnt_idx", 32'(GNT_IDX), 32'h0);
        chk("rst_busy",    32'(BUSY),    32'h0);
        chk("rst_preempt", 32'(PREEMPT), 32'h0);
        chk("rst_token",   32'(TOKEN),   32'h1);
        for (int i = 0; i < 20; i++) step(4'b0000, 1'b0);
        chk("idle_token", 32'(TOKEN), 32'h1);

        // Single requester 2 for three cycles.
        step(4'b0100, 1'b0);
        chk("single_gnt", 32'(GNT),     32'h4);
        chk("single_idx", 32'(GNT_IDX), 32'h2);
        step(4'b0100, 1'b0);
        step(4'b0100, 1'b0);
        chk("single_gnt3", 32'(GNT), 32'h4);
        step(4'b0000, 1'b0);
        chk("single_rel_gnt",   32'(GNT),     32'h0);
        chk("single_rel_token", 32'(TOKEN),   32'h8);
        chk("single_rel_pre",   32'(PREEMPT), 32'h0);

        // Wrap: token at 3, requesters 0 and 2 -> 0 wins.
        step(4'b0101, 1'b0);
        chk("wrap_gnt", 32'(GNT),     32'h1);
        chk("wrap_idx", 32'(GNT_IDX), 32'h0);
        step(4'b0000, 1'b0);
        step(4'b0000, 1'b0);

        // Rotation with all requesting, two-cycle tenures.
        step(4'b0000, 1'b1);
        for (int i = 0; i < 5; i++) begin
            k = i % N;
            step(4'b1111, 1'b0);
            chk("rot_gnt_a", 32'(GNT), 32'(1 << k));
            step(4'b1111, 1'b0);
            chk("rot_gnt_b", 32'(GNT), 32'(1 << k));
            step(4'b1111 & ~N'(1 << k), 1'b0);
            chk("rot_gap", 32'(GNT), 32'h0);
        end
        step(4'b0000, 1'b0);

        // Preemption with REQ=0011 held.
        step(4'b0000, 1'b1);
        for (int i = 0; i < MH; i++) begin
            step(4'b0011, 1'b0);
            chk("pre_gnt0", 32'(GNT), 32'h1);
        end
        step(4'b0011, 1'b0);
        chk("pre_gap0_gnt", 32'(GNT),     32'h0);
        chk("pre_gap0_pre", 32'(PREEMPT), 32'h1);
        for (int i = 0; i < MH; i++) begin
            step(4'b0011, 1'b0);
            chk("pre_gnt1", 32'(GNT), 32'h2);
        end
        step(4'b0011, 1'b0);
        chk("pre_gap1_pre", 32'(PREEMPT), 32'h1);
        step(4'b0011, 1'b0);
        chk("pre_back0", 32'(GNT), 32'h1);
        chk("pre_back0_pre", 32'(PREEMPT), 32'h0);

        // Owner drop on the same edge the limit is reached: normal release.
        for (int i = 0; i < MH - 1; i++) step(4'b0011, 1'b0);
        step(4'b0010, 1'b0);
        chk("limit_drop_pre", 32'(PREEMPT), 32'h0);
        chk("limit_drop_gnt", 32'(GNT),     32'h0);

        // Reset in the middle of a grant to requester 1.
        step(4'b0000, 1'b1);
        step(4'b0010, 1'b0);
        step(4'b0010, 1'b0);
        step(4'b0010, 1'b0);
        chk("mid_gnt", 32'(GNT), 32'h2);
        step(4'b0010, 1'b1);
        chk("mid_rst_gnt",   32'(GNT),     32'h0);
        chk("mid_rst_token", 32'(TOKEN),   32'h1);
        chk("mid_rst_pre",   32'(PREEMPT), 32'h0);
        step(4'b0010, 1'b0);
        chk("mid_regrant", 32'(GNT), 32'h2);

        // Randomized phase: sticky requests that flip occasionally.
        rr = 4'b0000;
        for (int i = 0; i < 3000; i++) begin
            flip = 4'b0000;
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(0, 7) == 0) flip[b] = 1'b1;
            end
            rr = rr ^ flip;
            step(rr, ($urandom_range(0, 299) == 0) ? 1'b1 : 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/ring_token_arbiter.md
# ring_token_arbiter

Round-robin arbiter that shares one resource, such as a ring-counter-timed datapath slot, among N_REQ requesters. A one-hot token register rotates like a ring counter and marks the highest-priority requester. The arbiter issues a registered one-hot grant and bounds each tenure to MAX_HOLD cycles. It sits between requesting masters and the shared resource, and its GNT lines drive the resource's select/enable.

## Interface
- N_REQ, default 4: number of requesters, ≥2.
- MAX_HOLD, default 8: maximum consecutive cycles one grant may stay asserted, ≥1.
- CK  in  1: single clock, rising edge.
- RST  in  1: reset, synchronous, active-high.
- REQ  in  N_REQ: request per requester; level, held until done.
- GNT  out  N_REQ: one-hot grant, or all-zero; registered.
- GNT_IDX  out  clog2(N_REQ): binary index of granted requester; 0 when no grant.
- BUSY  out  1: high when GNT ≠ 0.
- PREEMPT  out  1: one-cycle pulse when a grant was removed by the hold limit.
- TOKEN  out  N_REQ: current one-hot priority pointer.

## Operation
- Reset values, one edge after RST=1 sampled: state IDLE, GNT=0, GNT_IDX=0, BUSY=0, PREEMPT=0, TOKEN=1 (bit 0), hold counter=0.
- RST overrides everything, in any state, mid-grant included.
- States:
  - IDLE: no grant.
  - GRANT: owner k holds GNT[k].
  - GAP: one dead cycle after a release, no grant.
- Pick rule, applied in IDLE and GAP:
  - Scan REQ circularly starting at the TOKEN index, upward, wrapping N_REQ-1→0.
  - The first set bit wins.
  - If REQ=0, stay in or go to IDLE.
- IDLE/GAP → GRANT:
  - Taken on an edge where REQ≠0.
  - Load GNT=onehot(winner) and GNT_IDX=winner.
  - Hold counter=1.
- GRANT, owner k:
  - REQ[k] sampled 0 → GAP (normal release).
  - Else if hold counter==MAX_HOLD → GAP with PREEMPT=1 (forced release).
  - Else stay in GRANT and increment the counter.
- On entering GAP:
  - GNT=0, GNT_IDX=0.
  - TOKEN=onehot((k+1) mod N_REQ).
  - Counter cleared.
- PREEMPT is high only during the GAP cycle that follows a forced release.
- REQ changes of non-owners during GRANT are ignored.
- If the owner drops REQ on the same edge the limit is reached, it counts as a normal release and PREEMPT=0.
- A preempted owner that still requests competes normally in GAP. The token has moved past it, so it is served last.
- In IDLE, TOKEN does not move.
- GNT is always one-hot or zero, and BUSY=|GNT.

## Timing
- Grant latency: GNT rises on the first CK edge at which REQ is sampled in IDLE, i.e. 1 cycle.
- Release latency: GNT falls on the edge at which REQ[k]=0 is sampled.
- Minimum gap between two grants: 1 cycle (GAP).
- Maximum tenure: exactly MAX_HOLD cycles of GNT high.
- Worst-case wait for a continuously requesting input: (N_REQ-1)·(MAX_HOLD+1) cycles after its REQ is sampled.
- All outputs are registered; there are no combinational paths from REQ to GNT.

## Structure
- Package ring_arb_pkg holds:
  - typedef arb_state_t {IDLE, GRANT, GAP};
  - function onehot_to_idx;
  - function rotl1 (one-hot rotate-left with wrap).
- Sub-module ring_rr_pick, combinational: takes TOKEN and REQ, returns the winner one-hot and a found flag. Implement it by doubling the request vector, masking with the thermometer of TOKEN, and fixed-priority encoding.
- Hold counter width: clog2(MAX_HOLD+1).
- Top level holds the FSM, the counter and the TOKEN register.

## Test plan
All scenarios use N_REQ=4, MAX_HOLD=8.
- Reset then idle: RST for 2 cycles, REQ=0 → GNT=0, BUSY=0, TOKEN=0001 for 20 cycles.
- Single requester: REQ=0100 for 3 cycles, then 0 → GNT=0100 and GNT_IDX=2 for 3 cycles starting 1 cycle after REQ rises. Then GAP, TOKEN=1000, PREEMPT=0.
- Rotation with all requesting: REQ=1111, each owner drops REQ after 2 granted cycles and reasserts on the next cycle → grant order 0,1,2,3,0. Each tenure is 2 cycles, separated by single 0 cycles.
- Preemption: REQ=0011 held constant →
  - GNT=0001 for exactly 8 cycles, then 1 gap cycle with PREEMPT=1.
  - Then GNT=0010 for 8 cycles, then GNT=0001 again.
- Wrap and priority: TOKEN=1000 after owner 2 releases, with REQ=0101 → winner 0 (wraps past 3), GNT_IDX=0.
- Reset mid-grant: RST asserted on cycle 4 of GNT=0010 → next edge GNT=0, TOKEN=0001, PREEMPT=0. After RST falls, REQ=0010 is granted 1 cycle later.
